uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive-side buffer between the UART receiver and the MIPS core.
- Acknowledges every byte the UART flags as ready and stores it, with its parity/frame error bit, in a show-ahead FIFO.
- Presents the head byte to the core, which pops it with a one-cycle strobe.
- Decouples UART byte timing from core polling so back-to-back received characters are not lost.

Parameters:
- DEPTH, 16: FIFO entries; power of two, minimum 2.
- AW, 4: pointer width, log2(DEPTH).

Ports:
- clk  in  1  system clock (24 MHz domain, same as UART)
- rst_n  in  1  asynchronous active-low reset
- rdrf  in  1  UART received-data-ready flag; level, held until acknowledged
- rx_data  in  8  UART received byte; valid while rdrf=1
- frame_err  in  1  UART parity/frame error for the current byte; valid while rdrf=1
- rdrf_clr  out  1  one-cycle acknowledge pulse to the UART
- pop  in  1  consumer pop strobe; one entry per cycle held high
- dout  out  8  head byte; 8'h00 when empty
- dout_err  out  1  error bit of head entry; 0 when empty
- not_empty  out  1  FIFO holds at least one entry
- full  out  1  count == DEPTH
- count  out  AW+1  current occupancy
- overflow  out  1  sticky: a byte was dropped because the FIFO was full
- ovf_clr  in  1  clears overflow

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: rdrf_clr=0, count=0, not_empty=0, full=0, overflow=0, dout=8'h00, dout_err=0, pointers=0, capture FSM=IDLE. Storage array is not reset.
- Synchronisation: all inputs are synchronous to clk. rx is synchronised upstream; no further synchronisers here.

Capture FSM (IDLE, ACK, WAIT):
- IDLE:
  - If rdrf=1: write {frame_err, rx_data} at wr_ptr when push is allowed, otherwise drop the byte and set overflow. Go to ACK.
  - If rdrf=0: stay in IDLE.
- ACK: rdrf_clr=1 for exactly this cycle. Go to WAIT.
- WAIT: stay until rdrf=0, then IDLE. This ensures one level-held flag produces exactly one push.
- Latency: rdrf sampled high at edge N gives the write at edge N. not_empty and count are updated and visible after edge N. rdrf_clr is high in the cycle following edge N.
- rdrf_clr is a registered output (decoded from the ACK state); it is never combinational from rdrf.

FIFO:
- Push allowed when full=0, or when full=1 and pop=1 in the same cycle (simultaneous pop frees a slot).
- Pop on empty is ignored: no pointer or count change, no error.
- Simultaneous push and pop on a non-empty FIFO: count unchanged, both pointers advance.
- Simultaneous push and pop on an empty FIFO: the pop is ignored and the push is accepted; there is no bypass, so the byte appears next cycle.
- Pointers are AW bits and wrap modulo DEPTH. count is AW+1 bits, range 0..DEPTH.
- full and not_empty are derived from count.
- dout/dout_err are read combinationally from the rd_ptr entry, gated to 0 when count=0.

overflow:
- Set on a dropped byte.
- Cleared by ovf_clr. If set and clear occur in the same cycle, set wins.
- A dropped byte is still acknowledged via rdrf_clr so the UART continues receiving.

Reset mid-operation:
- Asserting rst_n low in ACK or WAIT returns the FSM to IDLE, with rdrf_clr=0 immediately (asynchronous).
- If rdrf is still high after reset release, it is treated as a new byte and pushed once.

Decomposition:
- Shared package uart_pkg:
  - capture state encodings ST_IDLE=2'd0, ST_ACK=2'd1, ST_WAIT=2'd2
  - RX_FIFO_DEPTH=16
  - BYTE_W=8
- One sub-module byte_fifo (parameters DEPTH, AW; width BYTE_W+1). It holds the storage, pointers, count, full/empty logic and the push/pop rules above.
- uart_rx_fifo contains the capture FSM, overflow logic and byte_fifo instance.

Test Plan:
- Single byte: reset, rdrf=1 with rx_data=8'h41, frame_err=0; release rdrf after rdrf_clr → exactly one rdrf_clr pulse, count=1, dout=8'h41, dout_err=0. Then pop one cycle → count=0, dout=8'h00.
- Held flag: keep rdrf=1 for 10 cycles with byte 8'h33 → single push (count=1), single rdrf_clr pulse, FSM stays in WAIT until rdrf falls.
- Fill and overflow: push 16 bytes 8'h00..8'h0F, then 8'hAA → full=1, count=16, overflow=1, 8'hAA dropped but rdrf_clr pulses. Pop all → order 8'h00..8'h0F. Pulse ovf_clr → overflow=0.
- Full with simultaneous pop: FIFO full, rdrf=1 with 8'h55 in the same cycle pop=1 → head advances, 8'h55 accepted, count stays 16, overflow=0.
- Error bit and wrap: push 20 bytes with interleaved pops so pointers wrap, with frame_err=1 on the 18th byte (8'h91) → dout_err=1 only while 8'h91 is head; data order preserved across the wrap.
- Reset mid-ack: assert rst_n=0 during ACK → rdrf_clr drops immediately, count=0, overflow=0. Release with rdrf still high (8'h7E) → one new push of 8'h7E, one rdrf_clr pulse.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared constants and capture-state encoding for the UART receive
//            buffer.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int RX_FIFO_DEPTH = 16;
  localparam int BYTE_W        = 8;

  // Capture handshake states: wait for a flag, acknowledge it, wait for release
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_WAIT = 2'd2
  } cap_state_t;

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : byte_fifo
// Brief    : Show-ahead FIFO with occupancy count. A push into a full FIFO is
//            accepted when a pop frees a slot in the same cycle; a pop on an
//            empty FIFO is ignored. Head entry reads as zero when empty.
// Revision : 1.0 - initial release
// ============================================================================
module byte_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [AW:0]  count,
  output logic         full,
  output logic         not_empty
);

  localparam logic [AW:0]   c_CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   c_CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] c_PTR_ONE  = AW'(1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_pop_ok;
  logic w_push_ok;

  assign full      = (r_count == c_CNT_FULL);
  assign not_empty = (r_count != '0);
  assign count     = r_count;

  // A pop only counts when there is something to take; a pop on a full FIFO
  // frees the slot the simultaneous push lands in.
  assign w_pop_ok  = pop & not_empty;
  assign w_push_ok = push & (~full | pop);

  // Head entry is visible without a read cycle; forced to zero when empty
  assign rdata = not_empty ? r_mem[r_rd_ptr] : '0;

  // Storage write; array contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : Receive-side buffer between the UART receiver and the core.
//            Acknowledges each level-held ready flag exactly once, stores the
//            byte with its error bit, and flags bytes lost to a full FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = RX_FIFO_DEPTH,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdrf,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              frame_err,
  output logic              rdrf_clr,
  input  logic              pop,
  output logic [BYTE_W-1:0] dout,
  output logic              dout_err,
  output logic              not_empty,
  output logic              full,
  output logic [AW:0]       count,
  output logic              overflow,
  input  logic              ovf_clr
);

  cap_state_t r_state;
  cap_state_t w_state_nxt;
  logic       w_capture;
  logic       w_drop;
  logic       r_overflow;

  // Capture state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture next-state: take the byte on the first sampled flag, then ignore
  // the flag until the UART has released it
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rdrf) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_ACK;
        end
      end
      ST_ACK:  w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (!rdrf) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Acknowledge comes straight from the state register, so an async reset
  // removes it at once and it never follows rdrf combinationally
  assign rdrf_clr = (r_state == ST_ACK);

  // Byte is lost only if the FIFO is full and no pop frees a slot
  assign w_drop = w_capture & full & ~pop;

  // Sticky overflow flag; a new drop takes priority over a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign overflow = r_overflow;

  byte_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (BYTE_W + 1)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_capture),
    .pop       (pop),
    .wdata     ({frame_err, rx_data}),
    .rdata     ({dout_err, dout}),
    .count     (count),
    .full      (full),
    .not_empty (not_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Brief    : Self-checking bench for uart_rx_fifo against a queue-based model
//            of the receive buffer and its one-push-per-flag handshake.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk;
  logic          rst_n;
  logic          rdrf;
  logic [7:0]    rx_data;
  logic          frame_err;
  logic          rdrf_clr;
  logic          pop;
  logic [7:0]    dout;
  logic          dout_err;
  logic          not_empty;
  logic          full;
  logic [AW:0]   count;
  logic          overflow;
  logic          ovf_clr;

  int n_checks;
  int n_errors;

  // Reference model state
  logic [8:0] m_q[$];
  bit         m_ovf;
  bit         m_clr;
  bit         m_ready;   // a raised flag will be taken as a new byte
  int         m_since;   // edges since the last taken byte

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rdrf      (rdrf),
    .rx_data   (rx_data),
    .frame_err (frame_err),
    .rdrf_clr  (rdrf_clr),
    .pop       (pop),
    .dout      (dout),
    .dout_err  (dout_err),
    .not_empty (not_empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf   = 1'b0;
    m_clr   = 1'b0;
    m_ready = 1'b1;
    m_since = 2;
  endtask

  // One clock edge of the receive buffer as seen from outside:
  // a flag is taken once, then ignored until seen low two or more edges later.
  task automatic model_edge(input bit r, input logic [7:0] d, input bit e,
                            input bit p, input bit oc);
    int n;
    bit cap, pop_ok, push_ok;
    n       = m_q.size();
    cap     = m_ready && r;
    pop_ok  = p && (n > 0);
    push_ok = cap && ((n < DEPTH) || p);
    if (pop_ok)  void'(m_q.pop_front());
    if (push_ok) m_q.push_back({e, d});
    if (cap && !push_ok) m_ovf = 1'b1;
    else if (oc)         m_ovf = 1'b0;
    m_clr = cap;
    if (cap) begin
      m_ready = 1'b0;
      m_since = 0;
    end else begin
      m_since++;
      if (m_since >= 2 && !r) m_ready = 1'b1;
    end
  endtask

  task automatic compare_all();
    logic [8:0] head;
    head = (m_q.size() > 0) ? m_q[0] : 9'h000;
    check_val("count",     32'(count),     32'(m_q.size()));
    check_val("full",      32'(full),      32'(m_q.size() == DEPTH));
    check_val("not_empty", 32'(not_empty), 32'(m_q.size() != 0));
    check_val("dout",      32'(dout),      32'(head[7:0]));
    check_val("dout_err",  32'(dout_err),  32'(head[8]));
    check_val("overflow",  32'(overflow),  32'(m_ovf));
    check_val("rdrf_clr",  32'(rdrf_clr),  32'(m_clr));
  endtask

  // Drive inputs at the falling edge, advance one cycle, check after the edge
  task automatic tick(input bit r, input logic [7:0] d, input bit e,
                      input bit p, input bit oc);
    rdrf = r; rx_data = d; frame_err = e; pop = p; ovf_clr = oc;
    @(posedge clk);
    model_edge(r, d, e, p, oc);
    @(negedge clk);
    compare_all();
  endtask

  // One UART byte: flag up for one cycle, then released long enough to re-arm
  task automatic send(input logic [7:0] d, input bit e, input bit p0,
                      input bit p1, input bit p2);
    tick(1'b1, d, e, p0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, p1, 1'b0);
    tick(1'b0, 8'h00, 1'b0, p2, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0; rdrf = 1'b0; rx_data = 8'h00; frame_err = 1'b0;
    pop = 1'b0; ovf_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // Single byte then a pop
    send(8'h41, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("single_dout", 32'(dout), 32'h41);
    tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check_val("single_popped", 32'(count), 32'd0);

    // Flag held for ten cycles gives one push and one acknowledge
    for (int i = 0; i < 10; i++) tick(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check_val("held_count", 32'(count), 32'd1);
    tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Fill, overflow on the 17th byte, drain in order, clear the flag
    for (int i = 0; i < DEPTH; i++) send(8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("ovf_set", 32'(overflow), 32'd1);
    drain();
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check_val("ovf_cleared", 32'(overflow), 32'd0);

    // Full FIFO with a pop in the capture cycle keeps the new byte
    for (int i = 0; i < DEPTH; i++) send(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("fullpop_count", 32'(count), 32'd16);
    drain();

    // Twenty bytes with random pops so pointers wrap; error on the 18th
    for (int i = 1; i <= 20; i++) begin
      send((i == 18) ? 8'h91 : 8'($urandom_range(0, 127)), (i == 18),
           1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();

    // Unconstrained random traffic
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
    end
    drain();

    // Reset in the acknowledge cycle of a dropped byte, flag still high after
    for (int i = 0; i < DEPTH; i++) send(8'(i + 8'h20), 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 8'h7E, 1'b0, 1'b0, 1'b0);
    check_val("mid_ack_clr", 32'(rdrf_clr), 32'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_val("rst_clr_async", 32'(rdrf_clr), 32'd0);
    check_val("rst_count",     32'(count),    32'd0);
    check_val("rst_ovf",       32'(overflow), 32'd0);
    @(negedge clk);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    tick(1'b1, 8'h7E, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 8'h7E, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check_val("post_rst_count", 32'(count), 32'd1);
    check_val("post_rst_dout",  32'(dout),  32'h7E);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
